// File: rtl/ks8_mpadd_arb.sv
// ks8_mpadd_arb: two-requester arbiter sharing one 8-bit Kogge-Stone slice for byte-serial multi-precision add.
// Operands are latched on accept; one limb is added per RUN cycle through a registered carry.
module ks8 (
    input  logic [7:0] x1,
    input  logic [7:0] x2,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);
    logic [7:0] p, g0, g1, p1, g2, p2, g3;
    assign p  = x1 ^ x2;
    // Fold carry-in into bit 0's generate so the prefix tree yields carries including cin
    assign g0 = (x1 & x2) | {7'b0, p[0] & cin};
    assign g1 = g0 | (p & {g0[6:0], 1'b0});
    assign p1 = p & {p[6:0], 1'b1};
    assign g2 = g1 | (p1 & {g1[5:0], 2'b0});
    assign p2 = p1 & {p1[5:0], 2'b11};
    assign g3 = g2 | (p2 & {g2[3:0], 4'b0});
    assign s    = p ^ {g3[6:0], cin};
    assign cout = g3[7];
endmodule

module ks8_mpadd_arb #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [8*WORDS-1:0]   req0_a,
    input  logic [8*WORDS-1:0]   req0_b,
    input  logic                 req0_cin,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [8*WORDS-1:0]   req1_a,
    input  logic [8*WORDS-1:0]   req1_b,
    input  logic                 req1_cin,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [8*WORDS-1:0]   res_sum,
    output logic                 res_cout,
    output logic                 res_id,
    output logic                 busy
);
    localparam int W  = 8 * WORDS;
    localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic [W-1:0] opa, opb, sum;
    logic [IW-1:0] idx;
    logic [7:0] s;
    logic carry, id, rr_last, gnt, any_req, accept, last, s_cout;
    assign any_req = req0_valid | req1_valid;
    assign gnt     = (req0_valid & req1_valid) ? ~rr_last : req1_valid;
    assign accept  = (state == IDLE) & any_req;
    assign last    = idx == IW'(WORDS - 1);
    ks8 u_add (
        .x1  (opa[8*idx +: 8]),
        .x2  (opb[8*idx +: 8]),
        .cin (carry),
        .s   (s),
        .cout(s_cout)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state == IDLE ? (any_req ? RUN : IDLE) :
                    state == RUN  ? (last ? DONE : RUN) :
                    (res_ready ? IDLE : DONE);
    end
    always_comb begin
        busy       = state != IDLE;
        res_valid  = state == DONE;
        req0_ready = accept & ~gnt;
        req1_ready = accept & gnt;
        res_sum    = sum;
        res_cout   = carry;
        res_id     = id;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa     <= '0;
            opb     <= '0;
            sum     <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            id      <= 1'b0;
            rr_last <= 1'b1;
        end else begin
            if (accept) begin
                opa   <= gnt ? req1_a : req0_a;
                opb   <= gnt ? req1_b : req0_b;
                carry <= gnt ? req1_cin : req0_cin;
                id    <= gnt;
                idx   <= '0;
            end
            if (state == RUN) begin
                sum[8*idx +: 8] <= s;
                carry           <= s_cout;
                if (!last) idx <= idx + 1'b1;
            end
            if (state == DONE && res_ready) rr_last <= id;
        end
    end
endmodule

// File: tb/tb_ks8_mpadd_arb.sv
// tb_ks8_mpadd_arb: directed and randomized checks of the shared-adder arbiter against an arithmetic/round-robin model.
module tb_ks8_mpadd_arb;
    localparam int WORDS = 4;
    localparam int W = 8 * WORDS;
    localparam int NR = 3000;
    logic clk = 0, rst_n = 0;
    logic req0_valid = 0, req0_cin = 0, req1_valid = 0, req1_cin = 0, res_ready = 0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic req0_ready, req1_ready, res_valid, res_cout, res_id, busy;
    logic [W-1:0] res_sum;
    int tests = 0, fails = 0;
    bit rr = 1;

    ks8_mpadd_arb #(.WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
        .res_id(res_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // Drives one operation from an idle DUT and reports what was observed; callers judge it.
    task automatic run_op(input bit v0, input logic [W-1:0] a0, b0, input bit c0,
                          input bit v1, input logic [W-1:0] a1, b1, input bit c1, input int hold,
                          output bit r0, r1, output int lat, output logic [W-1:0] sum,
                          output bit cout, id, stable);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
        lat = -1; stable = 0; sum = '0; cout = 0; id = 0;
        @(negedge clk);
        r0 = req0_ready; r1 = req1_ready;
        if (!(r0 | r1)) begin
            req0_valid = 0; req1_valid = 0;
            return;
        end
        @(posedge clk); #1;
        // Scramble the winner's inputs after accept: the result must not see them
        if (r0) begin req0_valid = 0; req0_a = $urandom; req0_b = $urandom; req0_cin = ~req0_cin; end
        if (r1) begin req1_valid = 0; req1_a = $urandom; req1_b = $urandom; req1_cin = ~req1_cin; end
        for (int i = 1; i <= 3 * WORDS + 4; i++) begin
            @(posedge clk); @(negedge clk);
            if (res_valid) begin lat = i; break; end
        end
        if (lat < 0) return;
        sum = res_sum; cout = res_cout; id = res_id; stable = 1;
        repeat (hold) begin
            @(posedge clk); @(negedge clk);
            if (!res_valid || res_sum !== sum || res_cout !== cout || res_id !== id ||
                req0_ready || req1_ready || !busy) stable = 0;
        end
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        tests++;
        if ({res_valid, res_sum, res_cout, res_id, busy, req0_ready, req1_ready} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b id=%b busy=%b rdy=%b%b, want all 0",
                     res_valid, res_sum, res_cout, res_id, busy, req0_ready, req1_ready);
        end
        rst_n = 1; rr = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_carry_chain();
        bit r0, r1, cout, id, st; int lat; logic [W-1:0] sum;
        run_op(1, 32'hFFFF_FFFF, 32'h1, 0, 0, '0, '0, 0, 0, r0, r1, lat, sum, cout, id, st);
        tests++;
        if ({r0, r1} !== 2'b10 || lat !== WORDS || sum !== 32'h0 || cout !== 1'b1 || id !== 1'b0) begin
            fails++;
            $display("FAIL full_carry: got rdy=%b%b lat=%0d sum=%h cout=%b id=%b, want rdy=10 lat=%0d sum=0 cout=1 id=0",
                     r0, r1, lat, sum, cout, id, WORDS);
        end
        rr = 0;
        run_op(0, '0, '0, 0, 1, 32'h0000_00FF, 32'h0, 1, 1, r0, r1, lat, sum, cout, id, st);
        tests++;
        if ({r0, r1} !== 2'b01 || lat !== WORDS || sum !== 32'h0000_0100 || cout !== 1'b0 || id !== 1'b1) begin
            fails++;
            $display("FAIL byte_carry: got rdy=%b%b lat=%0d sum=%h cout=%b id=%b, want rdy=01 lat=%0d sum=00000100 cout=0 id=1",
                     r0, r1, lat, sum, cout, id, WORDS);
        end
        rr = 1;
    endtask

    task automatic test_alternation();
        bit r0, r1, cout, id, st; int lat; logic [W-1:0] sum, a0, b0, a1, b1;
        bit c0, c1, g; logic [W:0] exp;
        for (int i = 0; i < 4; i++) begin
            a0 = $urandom; b0 = $urandom; c0 = $urandom; a1 = $urandom; b1 = $urandom; c1 = $urandom;
            g = bit'(i % 2);
            exp = g ? {1'b0, a1} + {1'b0, b1} + c1 : {1'b0, a0} + {1'b0, b0} + c0;
            run_op(1, a0, b0, c0, 1, a1, b1, c1, 0, r0, r1, lat, sum, cout, id, st);
            tests++;
            if ({r0, r1} !== {~g, g} || id !== g || {cout, sum} !== exp || lat !== WORDS) begin
                fails++;
                $display("FAIL alternate[%0d]: got rdy=%b%b id=%b res=%h lat=%0d, want rdy=%b%b id=%b res=%h lat=%0d",
                         i, r0, r1, id, {cout, sum}, lat, ~g, g, g, exp, WORDS);
            end
            rr = g;
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_backpressure();
        bit r0, r1, cout, id, st; int lat; logic [W-1:0] sum, a0, b0;
        logic [W:0] exp;
        a0 = $urandom; b0 = $urandom;
        exp = {1'b0, a0} + {1'b0, b0} + 1'b1;
        run_op(1, a0, b0, 1, 1, 32'h1234_5678, 32'h1, 0, 10, r0, r1, lat, sum, cout, id, st);
        tests++;
        if (!st || {cout, sum} !== exp || id !== ~rr || lat !== WORDS) begin
            fails++;
            $display("FAIL hold_stable: got stable=%b res=%h id=%b lat=%0d, want stable=1 res=%h id=%b lat=%0d",
                     st, {cout, sum}, id, lat, exp, ~rr, WORDS);
        end
        rr = ~rr;
        run_op(0, '0, '0, 0, 1, 32'h1234_5678, 32'h1, 0, 0, r0, r1, lat, sum, cout, id, st);
        tests++;
        if ({r0, r1} !== 2'b01 || sum !== 32'h1234_5679 || cout !== 1'b0 || id !== 1'b1) begin
            fails++;
            $display("FAIL resume_after_hold: got rdy=%b%b sum=%h cout=%b id=%b, want rdy=01 sum=12345679 cout=0 id=1",
                     r0, r1, sum, cout, id);
        end
        rr = 1;
    endtask

    task automatic test_reset_mid_run();
        bit r0, r1, cout, id, st; int lat; logic [W-1:0] sum;
        req0_valid = 1; req0_a = 32'hFFFF_FFFF; req0_b = 32'hFFFF_FFFF; req0_cin = 1;
        @(posedge clk); #1;
        req0_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 0;
        #1;
        tests++;
        if ({res_valid, res_sum, res_cout, res_id, busy, req0_ready, req1_ready} !== '0) begin
            fails++;
            $display("FAIL reset_mid_run: got valid=%b sum=%h cout=%b id=%b busy=%b, want all 0",
                     res_valid, res_sum, res_cout, res_id, busy);
        end
        @(negedge clk);
        rst_n = 1; rr = 1;
        @(posedge clk); #1;
        tests++;
        if ({res_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL no_result_after_reset: got valid=%b busy=%b, want 0 0", res_valid, busy);
        end
        run_op(1, 32'd5, 32'd7, 0, 1, 32'd9, 32'd9, 0, 0, r0, r1, lat, sum, cout, id, st);
        tests++;
        if ({r0, r1} !== 2'b10 || sum !== 32'd12 || cout !== 1'b0 || id !== 1'b0 || lat !== WORDS) begin
            fails++;
            $display("FAIL post_reset_op: got rdy=%b%b sum=%0d cout=%b id=%b lat=%0d, want rdy=10 sum=12 cout=0 id=0 lat=%0d",
                     r0, r1, sum, cout, id, lat, WORDS);
        end
        req1_valid = 0;
        rr = 0;
    endtask

    task automatic test_random();
        bit pv[2], pc[2];
        logic [W-1:0] pa[2], pb[2], sum;
        bit r0, r1, cout, id, st, g; int lat, done, hold; logic [W:0] exp;
        pv[0] = 0; pv[1] = 0; done = 0;
        for (int it = 0; done < NR && it < 4 * NR; it++) begin
            for (int k = 0; k < 2; k++)
                if (!pv[k] && $urandom_range(0, 1) == 1) begin
                    pv[k] = 1; pa[k] = $urandom; pb[k] = $urandom; pc[k] = 1'($urandom);
                    if ($urandom_range(0, 3) == 0) pa[k] = '1;
                end
            if (!pv[0] && !pv[1]) begin
                @(posedge clk); #1;
                continue;
            end
            g = (pv[0] && pv[1]) ? ~rr : pv[1];
            hold = $urandom_range(0, 3);
            exp = {1'b0, pa[g]} + {1'b0, pb[g]} + pc[g];
            run_op(pv[0], pa[0], pb[0], pc[0], pv[1], pa[1], pb[1], pc[1], hold,
                   r0, r1, lat, sum, cout, id, st);
            tests++;
            if ({r0, r1} !== {~g, g} || lat !== WORDS || {cout, sum} !== exp || id !== g || !st) begin
                fails++;
                $display("FAIL random[%0d]: got rdy=%b%b lat=%0d res=%h id=%b stable=%b, want rdy=%b%b lat=%0d res=%h id=%b stable=1",
                         done, r0, r1, lat, {cout, sum}, id, st, ~g, g, WORDS, exp, g);
            end
            pv[g] = 0; rr = g; done++;
        end
        tests++;
        if (done !== NR) begin
            fails++;
            $display("FAIL random_count: got %0d ops, want %0d", done, NR);
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_alternation();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
